oppm_tx_arbiter: RTL and testbench
==================================

// Module: oppm_tx_arbiter
// PURPOSE
//   Round-robin scheduler sharing one OPPM Encoder between NUM_REQ packet sources.
//   Latches the winning requester's packet, launches the Encoder and waits for it to finish.
//   Enforces a GAP_CT-tick idle gap between packets and reports per-source accept and done.
//   Sits between the link-layer packet sources and the Encoder start/data/avail interface.
// PARAMETERS
//   NUM_REQ  3   number of requesters, >=2
//   N_PKT    8   packet width in bits, equal to the Encoder N_PKT
//   GAP_CT   4   idle clock ticks between Encoder completion and the next launch, >=0
// PORTS
//   clk        in   1              clock
//   rst_n      in   1              reset, synchronous, active low
//   req        in   NUM_REQ        req[i] high = source i holds a packet; level, held until ack[i]
//   data       in   NUM_REQ*N_PKT  packet i on data[i*N_PKT +: N_PKT]
//   ack        out  NUM_REQ        one-cycle pulse: packet i latched, source may drop/change req/data
//   done       out  NUM_REQ        one-cycle pulse: packet i fully transmitted
//   enc_data   out  N_PKT          to Encoder data
//   enc_start  out  1              to Encoder start
//   enc_avail  in   1              from Encoder avail (high = Encoder idle)
//   busy       out  1              high in any state except IDLE
//   cur_id     out  $clog2(NUM_REQ)  index of the packet in flight; valid while busy
// BEHAVIOUR
//   Single clock (clk); reset is synchronous, active-low: all registers updated only at posedge clk.
//   Reset (rst_n=0 at posedge): state=IDLE, ptr=0, ack=0, done=0, enc_start=0, enc_data=0, busy=0, cur_id=0,
//     gap count=0. Reset mid-packet abandons it: no done pulse is issued, and the source must re-request.
//   Registered state machine IDLE -> LAUNCH -> BUSY -> GAP -> IDLE:
//   IDLE: if any req and enc_avail=1: pick the winner w = first set req[] searching ptr, ptr+1, .. mod NUM_REQ.
//     Same edge: latch data[w] into pkt register, cur_id<=w, ack[w]=1 for the next cycle,
//     ptr<=(w+1) mod NUM_REQ, go to LAUNCH. With no req, or enc_avail=0, remain in IDLE with no ack.
//   LAUNCH: enc_start=1, enc_data=pkt. Go to BUSY on the first cycle enc_avail=0 (Encoder left its idle state).
//     enc_start is combinational from state and drops in BUSY.
//   BUSY: enc_start=0, enc_data=pkt (held). On the first cycle enc_avail=1: done[cur_id]=1 for the next cycle.
//     Then go to GAP if GAP_CT>0, else go to IDLE.
//   GAP: counts GAP_CT cycles (counter width $clog2(GAP_CT+1), cleared on entry); on count==GAP_CT-1 go to IDLE.
//   Latency: req[i] high in IDLE -> ack[i] at +1 cycle, enc_start high in that same cycle.
//     Minimum req-to-req throughput = packet time + GAP_CT + 2.
//   ack and done are registered pulses, one-hot or zero, and never high for 2 consecutive cycles.
//   req sampled only in IDLE; a req dropped before its ack is simply skipped, with no error.
//   Simultaneous requests: exactly one ack per arbitration. ptr rotation guarantees every held req
//     is served within NUM_REQ packets (no starvation).
//   ack[w] may be asserted while req[w] is still high; the source must drop or refresh it.
//     If req[w] is still high at the next IDLE, it is a new packet.
//   enc_data is driven from the pkt register only; it never passes input data combinationally.
//   cur_id holds its value through GAP and after return to IDLE until the next grant.
// TESTING (NUM_REQ=3, N_PKT=8, GAP_CT=4, Encoder PULSE_CT=1 N_MOD=2 L=4 PRE_CT=3 behind it)
//   Single source: req=3'b010, data[1]=8'hA5 -> ack=3'b010 one cycle; enc_data=8'hA5; done=3'b010 after Encoder
//     completes; busy low exactly 4 cycles after GAP entry.
//   All three held continuously after reset -> grant order 0,1,2,0,1,2; each ack and done one-hot, no repeats.
//   ptr=1 with req=3'b101 -> grant 2 first, then 0; data[2]/data[0] seen on enc_data in that order.
//   Source drops req one cycle before its turn -> skipped; next set req granted, no stray ack/done.
//   rst_n=0 for 1 cycle during BUSY -> next cycle state IDLE, all outputs 0, ptr=0, no done pulse; re-arbitrates.
//   GAP_CT=0 build: done pulse followed by a new ack 1 cycle later when another req is pending.

Source files
------------

// File: rtl/oppm_tx_arbiter.sv
// Round-robin scheduler sharing one OPPM encoder between NUM_REQ packet sources; ack and enc_start
// follow a request seen in IDLE by one cycle, sources hold req until ack, launches are paced by enc_avail.
module oppm_tx_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int N_PKT   = 8,
  parameter int GAP_CT  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*N_PKT-1:0]   data,
  output logic [NUM_REQ-1:0]         ack,
  output logic [NUM_REQ-1:0]         done,
  output logic [N_PKT-1:0]           enc_data,
  output logic                       enc_start,
  input  logic                       enc_avail,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] cur_id
);

  localparam int IDW = $clog2(NUM_REQ);
  // Counter keeps one bit even in a zero-gap build so the GAP logic still elaborates.
  localparam int CW  = (GAP_CT > 0) ? $clog2(GAP_CT + 1) : 1;
  localparam logic [CW-1:0] GAP_LAST = (GAP_CT > 0) ? CW'(GAP_CT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_BUSY,
    S_GAP
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDW-1:0]     r_ptr;
  logic [IDW-1:0]     r_cur_id;
  logic [IDW-1:0]     w_win;
  logic [IDW-1:0]     w_cand;
  logic               w_found;
  logic               w_grant;
  logic               w_fin;
  logic [N_PKT-1:0]   r_pkt;
  logic [NUM_REQ-1:0] r_ack;
  logic [NUM_REQ-1:0] r_done;
  logic [NUM_REQ-1:0] w_ack_nxt;
  logic [NUM_REQ-1:0] w_done_nxt;
  logic [CW-1:0]      r_gap_cnt;
  logic [CW-1:0]      w_gap_cnt_nxt;

  // First set request searching upward from the rotating pointer.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = IDW'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_grant       = 1'b0;
    w_fin         = 1'b0;
    w_gap_cnt_nxt = r_gap_cnt;
    enc_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found && enc_avail) begin
          w_grant     = 1'b1;
          w_state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        enc_start = 1'b1;
        if (!enc_avail) begin
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (enc_avail) begin
          w_fin         = 1'b1;
          w_gap_cnt_nxt = '0;
          w_state_nxt   = (GAP_CT > 0) ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_ack_nxt  = '0;
    w_done_nxt = '0;
    if (w_grant) begin
      w_ack_nxt[w_win] = 1'b1;
    end
    if (w_fin) begin
      w_done_nxt[r_cur_id] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr     <= '0;
      r_cur_id  <= '0;
      r_pkt     <= '0;
      r_ack     <= '0;
      r_done    <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_ack     <= w_ack_nxt;
      r_done    <= w_done_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      if (w_grant) begin
        r_pkt    <= data[int'(w_win)*N_PKT +: N_PKT];
        r_cur_id <= w_win;
        r_ptr    <= IDW'((int'(w_win) + 1) % NUM_REQ);
      end
    end
  end

  assign ack      = r_ack;
  assign done     = r_done;
  assign enc_data = r_pkt;
  assign busy     = (r_state != S_IDLE);
  assign cur_id   = r_cur_id;

endmodule

// File: tb/tb_oppm_tx_arbiter.sv
// Bench for oppm_tx_arbiter: main instance with GAP_CT=4 plus a GAP_CT=0 instance,
// each behind a behavioural encoder that stays busy ENC_LEN cycles per packet.
module tb_oppm_tx_arbiter;

  localparam int NR      = 3;
  localparam int NP      = 8;
  localparam int ENC_LEN = 28;
  localparam int BUDGET  = 600;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req;
  logic [NR*NP-1:0] data;
  logic [NR-1:0] ack;
  logic [NR-1:0] done;
  logic [NP-1:0] enc_data;
  logic          enc_start;
  logic          enc_avail = 1'b1;
  logic          busy;
  logic [1:0]    cur_id;

  logic [NR-1:0] g_req;
  logic [NR*NP-1:0] g_data;
  logic [NR-1:0] g_ack;
  logic [NR-1:0] g_done;
  logic [NP-1:0] g_enc_data;
  logic          g_enc_start;
  logic          g_enc_avail = 1'b1;
  logic          g_busy;
  logic [1:0]    g_cur_id;

  int enc_cnt   = 0;
  int g_enc_cnt = 0;
  int n_checks  = 0;
  int n_fail    = 0;

  int         exp_ack_id[$];
  logic [7:0] exp_ack_dat[$];
  int         exp_done_id[$];
  logic [2:0] prev_ack  = 3'b000;
  logic [2:0] prev_done = 3'b000;
  int         m_id;
  logic [7:0] m_dat;
  logic [2:0] m_oh;

  always #5 clk = ~clk;

  oppm_tx_arbiter #(.NUM_REQ(NR), .N_PKT(NP), .GAP_CT(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data(data), .ack(ack), .done(done),
    .enc_data(enc_data), .enc_start(enc_start), .enc_avail(enc_avail),
    .busy(busy), .cur_id(cur_id)
  );

  oppm_tx_arbiter #(.NUM_REQ(NR), .N_PKT(NP), .GAP_CT(0)) dut_g0 (
    .clk(clk), .rst_n(rst_n), .req(g_req), .data(g_data), .ack(g_ack), .done(g_done),
    .enc_data(g_enc_data), .enc_start(g_enc_start), .enc_avail(g_enc_avail),
    .busy(g_busy), .cur_id(g_cur_id)
  );

  // Encoder stand-ins: leave idle on a start, return to idle ENC_LEN cycles later.
  always @(negedge clk) begin
    if (enc_avail && enc_start === 1'b1) begin
      enc_avail = 1'b0;
      enc_cnt   = ENC_LEN;
    end else if (!enc_avail) begin
      enc_cnt = enc_cnt - 1;
      if (enc_cnt == 0) enc_avail = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (g_enc_avail && g_enc_start === 1'b1) begin
      g_enc_avail = 1'b0;
      g_enc_cnt   = ENC_LEN;
    end else if (!g_enc_avail) begin
      g_enc_cnt = g_enc_cnt - 1;
      if (g_enc_cnt == 0) g_enc_avail = 1'b1;
    end
  end

  // Scoreboard on the main instance: every ack/done must match the next queued expectation.
  always @(negedge clk) begin
    if (ack !== 3'b000) begin
      n_checks++;
      if (prev_ack !== 3'b000) begin
        n_fail++;
        $display("FAIL ack_back_to_back: ack=%b previous=%b, required a zero cycle between", ack, prev_ack);
      end
      n_checks++;
      if (exp_ack_id.size() == 0) begin
        n_fail++;
        $display("FAIL stray_ack: ack=%b, required no ack", ack);
      end else begin
        m_id  = exp_ack_id.pop_front();
        m_dat = exp_ack_dat.pop_front();
        m_oh  = 3'b000;
        m_oh[m_id] = 1'b1;
        if (ack !== m_oh) begin
          n_fail++;
          $display("FAIL grant_order: ack=%b, required %b", ack, m_oh);
        end
        n_checks++;
        if (enc_data !== m_dat || enc_start !== 1'b1) begin
          n_fail++;
          $display("FAIL launch_data: enc_data=%h enc_start=%b, required %h and 1", enc_data, enc_start, m_dat);
        end
        n_checks++;
        if (cur_id !== 2'(m_id)) begin
          n_fail++;
          $display("FAIL cur_id_at_ack: cur_id=%0d, required %0d", cur_id, m_id);
        end
      end
    end
    if (done !== 3'b000) begin
      n_checks++;
      if (prev_done !== 3'b000) begin
        n_fail++;
        $display("FAIL done_back_to_back: done=%b previous=%b, required a zero cycle between", done, prev_done);
      end
      n_checks++;
      if (exp_done_id.size() == 0) begin
        n_fail++;
        $display("FAIL stray_done: done=%b, required no done", done);
      end else begin
        m_id = exp_done_id.pop_front();
        m_oh = 3'b000;
        m_oh[m_id] = 1'b1;
        if (done !== m_oh) begin
          n_fail++;
          $display("FAIL done_order: done=%b, required %b", done, m_oh);
        end
      end
    end
    prev_ack  = ack;
    prev_done = done;
  end

  task automatic expect_pkt(input int id, input logic [7:0] d, input bit with_done);
    exp_ack_id.push_back(id);
    exp_ack_dat.push_back(d);
    if (with_done) exp_done_id.push_back(id);
  endtask

  task automatic drain(output bit ok);
    int t = 0;
    while ((exp_ack_id.size() != 0 || exp_done_id.size() != 0) && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    ok = (t < BUDGET);
  endtask

  task automatic wait_idle(output bit ok);
    int t = 0;
    while (busy !== 1'b0 && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    ok = (t < BUDGET);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (ack !== 3'b000 || done !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_pulses: ack=%b done=%b, required 000/000", ack, done);
    end
    n_checks++;
    if (enc_start !== 1'b0 || enc_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_enc: enc_start=%b enc_data=%h, required 0/00", enc_start, enc_data);
    end
    n_checks++;
    if (busy !== 1'b0 || cur_id !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b cur_id=%0d, required 0/0", busy, cur_id);
    end
    n_checks++;
    if (g_busy !== 1'b0 || g_ack !== 3'b000 || g_enc_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_gap0: busy=%b ack=%b enc_start=%b, required 0/000/0", g_busy, g_ack, g_enc_start);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    int cnt[3];
    int t;
    bit ok;
    cnt = '{0, 0, 0};
    data = {8'h30, 8'h20, 8'h10};
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 3; i++)
        expect_pkt(i, 8'(8'h10 * (i + 1) + r), 1'b1);
    req = 3'b111;
    t = 0;
    while ((req != 3'b000 || exp_done_id.size() != 0) && t < BUDGET * 6) begin
      @(negedge clk);
      t++;
      for (int i = 0; i < 3; i++) begin
        if (ack[i] === 1'b1) begin
          cnt[i]++;
          if (cnt[i] == 2) req[i] = 1'b0;
          else data[i*NP +: NP] = data[i*NP +: NP] + 8'h01;
        end
      end
    end
    n_checks++;
    if (t >= BUDGET * 6) begin
      n_fail++;
      $display("FAIL rr_timeout: grants per source %0d/%0d/%0d, required 2/2/2", cnt[0], cnt[1], cnt[2]);
    end
    drain(ok);
  endtask

  task automatic test_single_source();
    bit ok;
    int t;
    wait_idle(ok);
    data = '0;
    data[15:8] = 8'hA5;
    expect_pkt(1, 8'hA5, 1'b1);
    req = 3'b010;
    @(negedge clk);
    n_checks++;
    if (ack !== 3'b010 || enc_start !== 1'b1 || enc_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_latency: ack=%b enc_start=%b enc_data=%h, required 010/1/a5", ack, enc_start, enc_data);
    end
    req = 3'b000;
    @(negedge clk);
    n_checks++;
    if (ack !== 3'b000) begin
      n_fail++;
      $display("FAIL single_ack_pulse: ack=%b, required 000", ack);
    end
    t = 0;
    while (done !== 3'b010 && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (t >= BUDGET) begin
      n_fail++;
      $display("FAIL single_done_timeout: done=%b, required 010 within %0d cycles", done, BUDGET);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL gap_busy_early: busy=%b 3 cycles after gap entry, required 1", busy);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_busy_late: busy=%b 4 cycles after gap entry, required 0", busy);
    end
    drain(ok);
  endtask

  task automatic test_ptr_rotation();
    bit ok;
    int t;
    int n0;
    int got[$];
    wait_idle(ok);
    data = '0;
    data[7:0] = 8'h5A;
    expect_pkt(0, 8'h5A, 1'b1);
    expect_pkt(2, 8'h3C, 1'b1);
    expect_pkt(0, 8'hC3, 1'b1);
    req = 3'b001;
    n0 = 0;
    t = 0;
    while ((n0 < 2 || exp_done_id.size() != 0) && t < BUDGET * 3) begin
      @(negedge clk);
      t++;
      if (ack === 3'b100) begin
        got.push_back(2);
        req[2] = 1'b0;
      end else if (ack === 3'b001) begin
        got.push_back(0);
        if (n0 == 0) begin
          req = 3'b101;
          data[7:0]   = 8'hC3;
          data[23:16] = 8'h3C;
        end else begin
          req[0] = 1'b0;
        end
        n0++;
      end else if (ack !== 3'b000) begin
        got.push_back(9);
      end
    end
    n_checks++;
    if (got.size() != 3 || got[0] != 0 || got[1] != 2 || got[2] != 0) begin
      n_fail++;
      $display("FAIL ptr_order: %0d grants first=%0d second=%0d, required 3 grants 0,2,0",
               got.size(), (got.size() > 0) ? got[0] : -1, (got.size() > 1) ? got[1] : -1);
    end
    drain(ok);
  endtask

  task automatic test_skip_dropped();
    bit ok;
    bit saw_ack1;
    int t;
    int phase;
    int k;
    wait_idle(ok);
    data = '0;
    data[7:0] = 8'h77;
    expect_pkt(0, 8'h77, 1'b1);
    expect_pkt(2, 8'h99, 1'b1);
    req = 3'b001;
    saw_ack1 = 1'b0;
    phase = 0;
    k = 0;
    t = 0;
    while (!(phase == 4 && exp_done_id.size() == 0) && t < BUDGET * 3) begin
      @(negedge clk);
      t++;
      if (ack[1] === 1'b1) saw_ack1 = 1'b1;
      case (phase)
        0: if (ack === 3'b001) begin
             req = 3'b110;
             data[15:8]  = 8'hEE;
             data[23:16] = 8'h99;
             phase = 1;
           end
        1: if (done === 3'b001) phase = 2;
        2: begin
             k++;
             if (k == 3) begin
               req[1] = 1'b0;
               phase = 3;
             end
           end
        3: if (ack === 3'b100) begin
             req = 3'b000;
             phase = 4;
           end
        default: ;
      endcase
    end
    repeat (40) begin
      @(negedge clk);
      if (ack[1] === 1'b1) saw_ack1 = 1'b1;
    end
    n_checks++;
    if (t >= BUDGET * 3 || saw_ack1) begin
      n_fail++;
      $display("FAIL skip_dropped: phase=%0d ack1_seen=%b, required phase 4 and no ack to source 1", phase, saw_ack1);
    end
  endtask

  task automatic test_reset_mid_packet();
    bit ok;
    int t;
    int stray;
    wait_idle(ok);
    data = '0;
    data[15:8] = 8'h42;
    expect_pkt(1, 8'h42, 1'b0);
    req = 3'b010;
    t = 0;
    while (ack !== 3'b010 && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    req = 3'b000;
    while (!(busy === 1'b1 && enc_start === 1'b0) && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (t >= BUDGET) begin
      n_fail++;
      $display("FAIL rst_reach_busy: busy=%b enc_start=%b, required BUSY state within %0d cycles", busy, enc_start, BUDGET);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (busy !== 1'b0 || enc_start !== 1'b0 || enc_data !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: busy=%b enc_start=%b enc_data=%h, required 0/0/00", busy, enc_start, enc_data);
    end
    n_checks++;
    if (ack !== 3'b000 || done !== 3'b000 || cur_id !== 2'd0) begin
      n_fail++;
      $display("FAIL rst_mid_ids: ack=%b done=%b cur_id=%0d, required 000/000/0", ack, done, cur_id);
    end
    stray = 0;
    repeat (ENC_LEN + 10) begin
      @(negedge clk);
      if (done !== 3'b000) stray++;
    end
    n_checks++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL rst_no_done: %0d done pulses after reset, required 0", stray);
    end
    data[15:8]  = 8'h81;
    data[23:16] = 8'h18;
    expect_pkt(1, 8'h81, 1'b1);
    expect_pkt(2, 8'h18, 1'b1);
    req = 3'b110;
    t = 0;
    while ((req != 3'b000 || exp_done_id.size() != 0) && t < BUDGET * 2) begin
      @(negedge clk);
      t++;
      if (ack === 3'b010) req[1] = 1'b0;
      if (ack === 3'b100) req[2] = 1'b0;
    end
    n_checks++;
    if (t >= BUDGET * 2) begin
      n_fail++;
      $display("FAIL rst_rearb_timeout: req=%b pending=%0d, required 000 and 0", req, exp_done_id.size());
    end
    drain(ok);
  endtask

  task automatic test_gap_zero();
    int t;
    g_data = {8'h00, 8'hB2, 8'hB1};
    g_req = 3'b011;
    t = 0;
    while (g_ack === 3'b000 && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (g_ack !== 3'b001 || g_enc_data !== 8'hB1) begin
      n_fail++;
      $display("FAIL gap0_first_grant: ack=%b enc_data=%h, required 001/b1", g_ack, g_enc_data);
    end
    g_req[0] = 1'b0;
    t = 0;
    while (g_done === 3'b000 && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (g_done !== 3'b001) begin
      n_fail++;
      $display("FAIL gap0_done: done=%b, required 001", g_done);
    end
    @(negedge clk);
    n_checks++;
    if (g_ack !== 3'b010 || g_enc_data !== 8'hB2) begin
      n_fail++;
      $display("FAIL gap0_back_to_back: ack=%b enc_data=%h one cycle after done, required 010/b2", g_ack, g_enc_data);
    end
    g_req = 3'b000;
    t = 0;
    while (g_done === 3'b000 && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (g_done !== 3'b010) begin
      n_fail++;
      $display("FAIL gap0_second_done: done=%b, required 010", g_done);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    req    = '0;
    data   = '0;
    g_req  = '0;
    g_data = '0;
    test_reset();
    test_round_robin();
    test_single_source();
    test_ptr_rotation();
    test_skip_dropped();
    test_reset_mid_packet();
    test_gap_zero();
    repeat (5) @(negedge clk);
    n_checks++;
    if (exp_ack_id.size() != 0 || exp_done_id.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expectations: acks=%0d dones=%0d outstanding, required 0/0",
               exp_ack_id.size(), exp_done_id.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
